// File: rtl/lane_gearbox.sv
// Sensor-lane gearbox: de-interleaves a LANES-wide sample bus, assembles WORD_BITS words
// per lane with per-lane polarity inversion and independent bit-slip alignment.
module lane_gearbox #(
  parameter int               LANES       = 4,
  parameter int               IN_BITS     = 6,
  parameter int               WORD_BITS   = 12,
  parameter logic [LANES-1:0] INVERT_MASK = {LANES{1'b1}}
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [LANES*IN_BITS-1:0]   in_data,
  input  logic                       in_valid,
  input  logic [LANES-1:0]           bitslip,
  output logic [LANES*WORD_BITS-1:0] out_data,
  output logic                       out_valid
);

  localparam int SAFE_IN = (IN_BITS > 0) ? IN_BITS : 1;
  localparam int RATIO   = WORD_BITS / SAFE_IN;
  localparam int PW      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OW      = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int SW      = $clog2(2 * WORD_BITS) + 1;

  generate
    if (IN_BITS == 0 || (WORD_BITS % SAFE_IN) != 0) begin : g_bad_cfg
      $error("lane_gearbox: WORD_BITS must be a non-zero multiple of IN_BITS");
    end
  endgenerate

  logic [PW-1:0] phase_r;
  logic          complete_s;
  logic          out_valid_r;

  assign complete_s = in_valid && (phase_r == PW'(RATIO - 1));
  assign out_valid  = out_valid_r;

  // Beat phase counter and the word strobe that follows a completing beat.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= complete_s;
      if (complete_s) begin
        phase_r <= '0;
      end else if (in_valid) begin
        phase_r <= phase_r + PW'(1);
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [2*WORD_BITS-1:0] sr_r;
    logic [2*WORD_BITS-1:0] sr_next_s;
    logic [IN_BITS-1:0]     beat_s;
    logic [OW-1:0]          off_r;
    logic [SW-1:0]          base_s;
    logic [WORD_BITS-1:0]   word_r;

    // Extract this lane's bits from the interleaved bus and form the post-shift history.
    always_comb begin
      beat_s = '0;
      for (int k = 0; k < IN_BITS; k++) begin
        beat_s[k] = in_data[k*LANES + l] ^ INVERT_MASK[l];
      end
      sr_next_s = {beat_s, sr_r[2*WORD_BITS-1:IN_BITS]};
      // Larger offset moves the window toward older bits.
      base_s    = SW'(WORD_BITS) - SW'(off_r);
    end

    // History, alignment offset and output word for this lane.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sr_r   <= '0;
        off_r  <= '0;
        word_r <= '0;
      end else begin
        if (in_valid) begin
          sr_r <= sr_next_s;
        end else begin
          sr_r <= sr_r;
        end
        if (bitslip[l]) begin
          off_r <= (off_r == OW'(WORD_BITS - 1)) ? '0 : off_r + OW'(1);
        end else begin
          off_r <= off_r;
        end
        if (complete_s) begin
          word_r <= sr_next_s[base_s +: WORD_BITS];
        end else begin
          word_r <= word_r;
        end
      end
    end

    assign out_data[l*WORD_BITS +: WORD_BITS] = word_r;
  end

endmodule

// File: tb/tb_lane_gearbox.sv
// Self-checking bench for lane_gearbox: directed scenarios plus randomized traffic,
// compared against a per-lane bit-stream reference model.
module tb_lane_gearbox;

  localparam int         LANES     = 4;
  localparam int         IN_BITS   = 6;
  localparam int         WORD_BITS = 12;
  localparam int         RATIO     = WORD_BITS / IN_BITS;
  localparam logic [3:0] INV       = 4'hF;
  localparam int         DEPTH     = 8192;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [23:0] in_data   = 24'h0;
  logic        in_valid  = 1'b0;
  logic [3:0]  bitslip   = 4'h0;
  logic [47:0] out_data;
  logic        out_valid;

  lane_gearbox #(
    .LANES(LANES), .IN_BITS(IN_BITS), .WORD_BITS(WORD_BITS), .INVERT_MASK(INV)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
    .bitslip(bitslip), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: every captured bit per lane in arrival order, oldest first.
  bit          stream [LANES][DEPTH];
  int          nbits;
  int          nbeats;
  int          off_m [LANES];
  logic [47:0] exp_data;
  logic        exp_valid;

  function automatic logic [23:0] mk(input logic [5:0] v0, input logic [5:0] v1,
                                     input logic [5:0] v2, input logic [5:0] v3);
    logic [5:0]  v [4];
    logic [23:0] d;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    d = 24'h0;
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < IN_BITS; k++)
        d[k*LANES + l] = v[l][k] ^ INV[l];
    return d;
  endfunction

  task automatic model_reset();
    nbits = 0; nbeats = 0; exp_data = 48'h0; exp_valid = 1'b0;
    for (int l = 0; l < LANES; l++) off_m[l] = 0;
  endtask

  task automatic step(input logic [23:0] d, input logic v, input logic [3:0] s);
    int idx;
    in_data = d; in_valid = v; bitslip = s;
    @(posedge sys_clk);
    exp_valid = 1'b0;
    if (v) begin
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < IN_BITS; k++)
          stream[l][(nbits + k) % DEPTH] = d[k*LANES + l] ^ INV[l];
      nbits  += IN_BITS;
      nbeats += 1;
      if (nbeats % RATIO == 0) begin
        exp_valid = 1'b1;
        for (int l = 0; l < LANES; l++)
          for (int b = 0; b < WORD_BITS; b++) begin
            idx = nbits - WORD_BITS - off_m[l] + b;
            exp_data[l*WORD_BITS + b] = (idx < 0) ? 1'b0 : stream[l][idx % DEPTH];
          end
      end
    end
    for (int l = 0; l < LANES; l++)
      if (s[l]) off_m[l] = (off_m[l] + 1) % WORD_BITS;
    @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0; in_valid = 1'b0; bitslip = 4'h0; in_data = 24'h0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    in_data = 24'hABCDEF; in_valid = 1'b1; bitslip = 4'hF;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++;
    if (out_data !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    in_valid = 1'b0; bitslip = 4'h0;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_const_zero();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(24'h0, 1'b1, 4'h0);
      vectors++;
      if (out_valid !== (i % 2 == 1)) begin
        errors++; $display("FAIL const_valid[%0d] got %b want %b", i, out_valid, (i % 2 == 1));
      end
      vectors++;
      if (out_valid && out_data !== 48'hFFFF_FFFF_FFFF) begin
        errors++; $display("FAIL const_data[%0d] got %h want ffffffffffff", i, out_data);
      end
    end
  endtask

  task automatic test_pattern();
    apply_reset();
    step(mk(6'h15, 6'h00, 6'h00, 6'h00), 1'b1, 4'h0);
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pattern_valid1 got %b want 0", out_valid); end
    step(mk(6'h2A, 6'h00, 6'h00, 6'h00), 1'b1, 4'h0);
    vectors++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pattern_valid2 got %b want 1", out_valid); end
    vectors++;
    if (out_data !== 48'h0000_0000_0A95) begin
      errors++; $display("FAIL pattern_data got %h want 000000000a95", out_data);
    end
  endtask

  task automatic test_bitslip();
    apply_reset();
    for (int i = 0; i < 4; i++) step(mk((i % 2 == 0) ? 6'h15 : 6'h2A, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    step(24'h0, 1'b0, 4'h1);
    step(mk(6'h15, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    step(mk(6'h2A, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 48'h0000_0000_052B) begin
      errors++; $display("FAIL slip1 got %b/%h want 1/00000000052b", out_valid, out_data);
    end
    for (int i = 0; i < 11; i++) step(24'h0, 1'b0, 4'h1);
    step(mk(6'h15, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    step(mk(6'h2A, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 48'h0000_0000_0A95) begin
      errors++; $display("FAIL slip12 got %b/%h want 1/000000000a95", out_valid, out_data);
    end
    vectors++;
    if (out_data !== exp_data) begin errors++; $display("FAIL slip_model got %h want %h", out_data, exp_data); end
  endtask

  task automatic test_gaps();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(mk((i % 2 == 0) ? 6'h15 : 6'h2A, 6'h0, 6'h0, 6'h0), 1'b1, (i == 3) ? 4'h1 : 4'h0);
      for (int g = 0; g < 4; g++) begin
        vectors++;
        if (out_valid !== exp_valid || out_data !== exp_data) begin
          errors++;
          $display("FAIL gaps[%0d.%0d] got %b/%h want %b/%h", i, g, out_valid, out_data, exp_valid, exp_data);
        end
        if (g < 3) step(24'hFFFFFF, 1'b0, 4'h0);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(mk(6'h15, 6'h3, 6'h0, 6'h0), 1'b1, 4'h0);
    step(mk(6'h2A, 6'h3, 6'h0, 6'h0), 1'b1, 4'h0);
    step(mk(6'h15, 6'h3, 6'h0, 6'h0), 1'b1, 4'h2);
    #2 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 48'h0) begin
      errors++; $display("FAIL rst_mid got %b/%h want 0/0", out_valid, out_data);
    end
    model_reset();
    in_valid = 1'b0; bitslip = 4'h0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(mk(6'h2A, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_beat1 got %b want 0", out_valid); end
    step(mk(6'h15, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 48'h0000_0000_056A) begin
      errors++; $display("FAIL rst_beat2 got %b/%h want 1/00000000056a", out_valid, out_data);
    end
  endtask

  task automatic test_slip_coincident();
    apply_reset();
    step(mk(6'h15, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    step(mk(6'h2A, 6'h0, 6'h0, 6'h0), 1'b1, 4'h1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 48'h0000_0000_0A95) begin
      errors++; $display("FAIL coinc_old got %b/%h want 1/000000000a95", out_valid, out_data);
    end
    step(mk(6'h15, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    step(mk(6'h2A, 6'h0, 6'h0, 6'h0), 1'b1, 4'h0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 48'h0000_0000_052B) begin
      errors++; $display("FAIL coinc_new got %b/%h want 1/00000000052b", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    logic [23:0] d;
    logic        v;
    logic [3:0]  s;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      d = 24'($urandom);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      step(d, v, s);
      vectors++;
      if (out_valid !== exp_valid || out_data !== exp_data) begin
        errors++;
        $display("FAIL random[%0d] got %b/%h want %b/%h", i, out_valid, out_data, exp_valid, exp_data);
      end
    end
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_const_zero();
    test_pattern();
    test_bitslip();
    test_gaps();
    test_reset_mid();
    test_slip_coincident();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
